// File: rtl/param_direct_cache.sv
// rtl/param_direct_cache.sv - parametrised direct-mapped read cache (optional stats via PCACHE_STATS_EN)
module param_direct_cache #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int NUM_SETS       = 64,
  parameter int LINE_BEATS     = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      p_bus_reqcyc,
  output logic                      p_bus_reqack,
  input  logic [BUS_DATA_WIDTH-1:0] p_bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  p_bus_reqtag,
  output logic                      p_bus_respcyc,
  input  logic                      p_bus_respack,
  output logic [BUS_DATA_WIDTH-1:0] p_bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  p_bus_resptag,
  output logic                      m_bus_reqcyc,
  input  logic                      m_bus_reqack,
  output logic [BUS_DATA_WIDTH-1:0] m_bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  m_bus_reqtag,
  input  logic                      m_bus_respcyc,
  output logic                      m_bus_respack,
  input  logic [BUS_DATA_WIDTH-1:0] m_bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  m_bus_resptag
`ifdef PCACHE_STATS_EN
  ,
  output logic [31:0]               hit_count,
  output logic [31:0]               miss_count
`endif
);

  localparam int OFF   = $clog2(LINE_BEATS * BUS_DATA_WIDTH / 8);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int CNT_W = $clog2(LINE_BEATS);
  localparam int TAG_W = BUS_DATA_WIDTH - OFF - IDX_W;

  typedef enum logic [2:0] {IDLE, LOOKUP, MEMREQ, REFILL, RESPOND} state_t;

  state_t                    state, state_n;
  logic [CNT_W-1:0]          cnt, cnt_n;
  logic [BUS_DATA_WIDTH-1:0] addr_q;
  logic [BUS_TAG_WIDTH-1:0]  reqtag_q;
  logic [NUM_SETS-1:0]       valid_q;
  logic [TAG_W-1:0]          tag_mem  [NUM_SETS];
  logic [BUS_DATA_WIDTH-1:0] data_mem [NUM_SETS*LINE_BEATS];

  logic [IDX_W-1:0]          idx;
  logic [TAG_W-1:0]          line_tag;
  logic                      hit;
  logic                      accept;
  logic                      fill_we;
  logic                      line_we;
  logic                      last_beat;
  logic                      unused_ok;

  assign idx       = addr_q[OFF +: IDX_W];
  assign line_tag  = addr_q[BUS_DATA_WIDTH-1 -: TAG_W];
  assign hit       = valid_q[idx] && (tag_mem[idx] == line_tag);
  assign last_beat = (cnt == CNT_W'(LINE_BEATS - 1));
  assign unused_ok = ^{m_bus_resptag, addr_q[OFF-1:0]};

  // Next-state and output decode; everything defaults to idle/zero
  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    accept        = 1'b0;
    fill_we       = 1'b0;
    line_we       = 1'b0;
    p_bus_reqack  = 1'b0;
    p_bus_respcyc = 1'b0;
    p_bus_resp    = '0;
    p_bus_resptag = '0;
    m_bus_reqcyc  = 1'b0;
    m_bus_req     = '0;
    m_bus_reqtag  = '0;
    m_bus_respack = 1'b0;
    case (state)
      IDLE: begin
        if (p_bus_reqcyc && reset_n) begin
          p_bus_reqack = 1'b1;
          accept       = 1'b1;
          state_n      = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          cnt_n   = '0;
          state_n = RESPOND;
        end else begin
          state_n = MEMREQ;
        end
      end
      MEMREQ: begin
        m_bus_reqcyc = 1'b1;
        m_bus_req    = {addr_q[BUS_DATA_WIDTH-1:OFF], {OFF{1'b0}}};
        m_bus_reqtag = reqtag_q;
        if (m_bus_reqack) begin
          cnt_n   = '0;
          state_n = REFILL;
        end
      end
      REFILL: begin
        if (m_bus_respcyc) begin
          m_bus_respack = 1'b1;
          fill_we       = 1'b1;
          cnt_n         = cnt + 1'b1;
          if (last_beat) begin
            line_we = 1'b1;
            cnt_n   = '0;
            state_n = RESPOND;
          end
        end
      end
      RESPOND: begin
        p_bus_respcyc = 1'b1;
        p_bus_resp    = data_mem[{idx, cnt}];
        p_bus_resptag = reqtag_q;
        if (p_bus_respack) begin
          cnt_n = cnt + 1'b1;
          if (last_beat) begin
            cnt_n   = '0;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and beat counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Request address/tag latch, captured on acceptance
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q   <= '0;
      reqtag_q <= '0;
    end else if (accept) begin
      addr_q   <= p_bus_req;
      reqtag_q <= p_bus_reqtag;
    end
  end

  // Valid bits; a line only becomes valid once its last fill beat lands
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
    end else if (line_we) begin
      valid_q[idx] <= 1'b1;
    end
  end

  // Tag and data storage, deliberately left unreset
  always_ff @(posedge clk) begin
    if (fill_we) data_mem[{idx, cnt}] <= m_bus_resp;
    if (line_we) tag_mem[idx] <= line_tag;
  end

`ifdef PCACHE_STATS_EN
  // Saturating hit/miss counters, one event per lookup
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == LOOKUP) begin
      if (hit && hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
      if (!hit && miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_param_direct_cache.sv
// tb/tb_param_direct_cache.sv - directed self-checking bench for param_direct_cache
module tb_param_direct_cache;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        p_bus_reqcyc;
  logic        p_bus_reqack;
  logic [63:0] p_bus_req;
  logic [12:0] p_bus_reqtag;
  logic        p_bus_respcyc;
  logic        p_bus_respack;
  logic [63:0] p_bus_resp;
  logic [12:0] p_bus_resptag;
  logic        m_bus_reqcyc;
  logic        m_bus_reqack;
  logic [63:0] m_bus_req;
  logic [12:0] m_bus_reqtag;
  logic        m_bus_respcyc;
  logic        m_bus_respack;
  logic [63:0] m_bus_resp;
  logic [12:0] m_bus_resptag;
`ifdef PCACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  param_direct_cache dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .p_bus_reqcyc  (p_bus_reqcyc),
    .p_bus_reqack  (p_bus_reqack),
    .p_bus_req     (p_bus_req),
    .p_bus_reqtag  (p_bus_reqtag),
    .p_bus_respcyc (p_bus_respcyc),
    .p_bus_respack (p_bus_respack),
    .p_bus_resp    (p_bus_resp),
    .p_bus_resptag (p_bus_resptag),
    .m_bus_reqcyc  (m_bus_reqcyc),
    .m_bus_reqack  (m_bus_reqack),
    .m_bus_req     (m_bus_req),
    .m_bus_reqtag  (m_bus_reqtag),
    .m_bus_respcyc (m_bus_respcyc),
    .m_bus_respack (m_bus_respack),
    .m_bus_resp    (m_bus_resp),
    .m_bus_resptag (m_bus_resptag)
`ifdef PCACHE_STATS_EN
    ,
    .hit_count     (hit_count),
    .miss_count    (miss_count)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_p_reqack"},  64'(p_bus_reqack), 64'd0);
    check({pfx, "_p_respcyc"}, 64'(p_bus_respcyc), 64'd0);
    check({pfx, "_p_resp"},    p_bus_resp, 64'd0);
    check({pfx, "_p_resptag"}, 64'(p_bus_resptag), 64'd0);
    check({pfx, "_m_reqcyc"},  64'(m_bus_reqcyc), 64'd0);
    check({pfx, "_m_req"},     m_bus_req, 64'd0);
    check({pfx, "_m_reqtag"},  64'(m_bus_reqtag), 64'd0);
    check({pfx, "_m_respack"}, 64'(m_bus_respack), 64'd0);
  endtask

  // Present a request in IDLE; returns in cycle T+2 after the ack cycle T
  task automatic issue(input logic [63:0] addr, input logic [12:0] tag);
    p_bus_reqcyc = 1'b1;
    p_bus_req    = addr;
    p_bus_reqtag = tag;
    #1;
    check("reqack_idle", 64'(p_bus_reqack), 64'd1);
    tick();
    check("reqack_lookup", 64'(p_bus_reqack), 64'd0);
    check("lookup_quiet", 64'({p_bus_respcyc, m_bus_reqcyc}), 64'd0);
    p_bus_reqcyc = 1'b0;
    p_bus_req    = '0;
    p_bus_reqtag = '0;
    tick();
  endtask

  // Act as memory for one line fill; returns in the first RESPOND cycle
  task automatic serve_miss(input logic [63:0] exp_addr, input logic [12:0] exp_tag,
                            input logic [63:0] base, input int ack_delay, input bit gaps);
    int beat;
    int guard;
    bit gap;
    check("miss_reqcyc", 64'(m_bus_reqcyc), 64'd1);
    check("miss_m_req", m_bus_req, exp_addr);
    check("miss_m_reqtag", 64'(m_bus_reqtag), 64'(exp_tag));
    for (int d = 0; d < ack_delay; d++) begin
      tick();
      check("stall_reqcyc", 64'(m_bus_reqcyc), 64'd1);
      check("stall_m_req", m_bus_req, exp_addr);
    end
    m_bus_reqack = 1'b1;
    tick();
    m_bus_reqack = 1'b0;
    beat  = 0;
    guard = 0;
    while (beat < 8 && guard < 64) begin
      gap = gaps && (guard % 3 == 1);
      m_bus_respcyc = !gap;
      m_bus_resp    = gap ? 64'hDEAD : base + 64'(beat);
      #1;
      check("fill_respack", 64'(m_bus_respack), 64'(!gap));
      check("fill_no_presp", 64'(p_bus_respcyc), 64'd0);
      tick();
      if (!gap) beat++;
      guard++;
    end
    if (beat < 8) check("fill_budget", 64'(beat), 64'd8);
    m_bus_respcyc = 1'b0;
    m_bus_resp    = '0;
  endtask

  // Act as processor collecting a line; optional respack stall on one beat
  task automatic receive(input logic [63:0] base, input logic [12:0] tag,
                         input int stall_beat, input int stall_cycles);
    for (int i = 0; i < 8; i++) begin
      check("resp_cyc", 64'(p_bus_respcyc), 64'd1);
      check("resp_data", p_bus_resp, base + 64'(i));
      check("resp_tag", 64'(p_bus_resptag), 64'(tag));
      check("resp_no_mreq", 64'(m_bus_reqcyc), 64'd0);
      if (i == stall_beat) begin
        p_bus_respack = 1'b0;
        for (int s = 0; s < stall_cycles; s++) begin
          tick();
          check("stall_resp_data", p_bus_resp, base + 64'(i));
        end
      end
      p_bus_respack = 1'b1;
      tick();
    end
    p_bus_respack = 1'b0;
    check("after_respcyc", 64'(p_bus_respcyc), 64'd0);
    check("after_resp", p_bus_resp, 64'd0);
    check("after_resptag", 64'(p_bus_resptag), 64'd0);
  endtask

  initial begin
    reset_n       = 1'b1;
    p_bus_reqcyc  = 1'b1;
    p_bus_req     = '0;
    p_bus_reqtag  = '0;
    p_bus_respack = 1'b0;
    m_bus_reqack  = 1'b0;
    m_bus_respcyc = 1'b0;
    m_bus_resp    = '0;
    m_bus_resptag = 13'h1ABC;
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("reset");
    tick();
    tick();
    p_bus_reqcyc = 1'b0;
    reset_n      = 1'b1;
    tick();

    // Cold miss: index 1, tag 1
    issue(64'h1048, 13'h05);
    serve_miss(64'h1040, 13'h05, 64'h100, 0, 1'b0);
    receive(64'h100, 13'h05, -1, 0);

    // Hit on the same line, different offset; beats still start at 0
    issue(64'h1070, 13'h06);
    check("hit_t2_respcyc", 64'(p_bus_respcyc), 64'd1);
    receive(64'h100, 13'h06, -1, 0);

    // Conflict on index 1: tag 2 evicts tag 1, then tag 1 refetches new data
    issue(64'h2040, 13'h07);
    serve_miss(64'h2040, 13'h07, 64'h200, 0, 1'b0);
    receive(64'h200, 13'h07, -1, 0);
    issue(64'h1040, 13'h08);
    serve_miss(64'h1040, 13'h08, 64'h300, 0, 1'b0);
    receive(64'h300, 13'h08, -1, 0);
`ifdef PCACHE_STATS_EN
    check("stats_hits", 64'(hit_count), 64'd1);
    check("stats_misses", 64'(miss_count), 64'd3);
`endif

    // Backpressure: delayed reqack, fill gaps, respack stall on beat 2
    issue(64'h3018, 13'h1F0);
    serve_miss(64'h3000, 13'h1F0, 64'h400, 4, 1'b1);
    receive(64'h400, 13'h1F0, 2, 3);

    // Reset in the middle of a refill of index 1
    issue(64'h5040, 13'h09);
    check("rst_miss_m_req", m_bus_req, 64'h5040);
    m_bus_reqack = 1'b1;
    tick();
    m_bus_reqack = 1'b0;
    for (int b = 0; b < 4; b++) begin
      m_bus_respcyc = 1'b1;
      m_bus_resp    = 64'h500 + 64'(b);
      tick();
    end
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midfill");
    tick();
    m_bus_respcyc = 1'b0;
    m_bus_resp    = '0;
    reset_n       = 1'b1;
    tick();
    issue(64'h1040, 13'h0A);
    serve_miss(64'h1040, 13'h0A, 64'h600, 0, 1'b0);
    receive(64'h600, 13'h0A, -1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
